// File: rtl/bin_to_onehot_stream.sv
// Streaming binary-index to one-hot decoder with valid/ready on both sides and an out-of-range flag.
// Define BIN_TO_ONEHOT_SKID_EN for a two-entry skid buffer; the default build uses one pipeline register.
module bin_to_onehot_stream #(
  parameter int ONEHOT_WIDTH = 16,
  parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH)
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    flush_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [BIN_WIDTH-1:0]    bin_i,
  output logic                    valid_o,
  input  logic                    ready_i,
  output logic [ONEHOT_WIDTH-1:0] onehot_o,
  output logic                    oob_o
);

  localparam logic [BIN_WIDTH:0]    LIMIT = (BIN_WIDTH+1)'(ONEHOT_WIDTH);
  localparam logic [ONEHOT_WIDTH-1:0] ONE = ONEHOT_WIDTH'(1);

  logic                    in_oob;
  logic [ONEHOT_WIDTH-1:0] in_onehot;
  logic                    in_fire;

  logic                    out_valid;
  logic                    out_oob;
  logic [ONEHOT_WIDTH-1:0] out_onehot;

  // Decode happens before storage so the buffer holds one-hot/oob directly.
  always_comb begin
    in_oob    = ({1'b0, bin_i} >= LIMIT);
    in_onehot = in_oob ? '0 : (ONE << bin_i);
  end

  assign in_fire  = valid_i & ready_o;
  assign valid_o  = out_valid;
  assign onehot_o = out_onehot;
  assign oob_o    = out_oob;

`ifdef BIN_TO_ONEHOT_SKID_EN

  logic                    skid_valid;
  logic                    skid_oob;
  logic [ONEHOT_WIDTH-1:0] skid_onehot;

  // Full only when the skid slot is occupied; no path from ready_i.
  assign ready_o = ~skid_valid & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid   <= 1'b0;
      out_oob     <= 1'b0;
      out_onehot  <= '0;
      skid_valid  <= 1'b0;
      skid_oob    <= 1'b0;
      skid_onehot <= '0;
    end else if (flush_i) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (~out_valid | ready_i) begin
      if (skid_valid) begin
        out_onehot <= skid_onehot;
        out_oob    <= skid_oob;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else if (in_fire) begin
        out_onehot <= in_onehot;
        out_oob    <= in_oob;
        out_valid  <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (in_fire) begin
      skid_onehot <= in_onehot;
      skid_oob    <= in_oob;
      skid_valid  <= 1'b1;
    end
  end

`else

  assign ready_o = (~out_valid | ready_i) & ~flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid  <= 1'b0;
      out_oob    <= 1'b0;
      out_onehot <= '0;
    end else if (flush_i) begin
      out_valid <= 1'b0;
    end else if (in_fire) begin
      out_onehot <= in_onehot;
      out_oob    <= in_oob;
      out_valid  <= 1'b1;
    end else if (ready_i) begin
      out_valid <= 1'b0;
    end
  end

`endif

endmodule

// File: tb/tb_bin_to_onehot_stream.sv
// Directed bench for bin_to_onehot_stream: a 16-wide and a 12-wide instance share clock and reset.
module tb_bin_to_onehot_stream;

`ifdef BIN_TO_ONEHOT_SKID_EN
  localparam int NPRE  = 2;
  localparam bit SKID  = 1'b1;
`else
  localparam int NPRE  = 1;
  localparam bit SKID  = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        flush = 1'b0, valid = 1'b0, ready = 1'b0;
  logic [3:0]  bin = '0;
  logic        rdy_o, vld_o, oob;
  logic [15:0] onehot;

  logic        flush12 = 1'b0, valid12 = 1'b0, ready12 = 1'b0;
  logic [3:0]  bin12 = '0;
  logic        rdy12_o, vld12_o, oob12;
  logic [11:0] onehot12;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bin_to_onehot_stream #(.ONEHOT_WIDTH(16)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .valid_i(valid), .ready_o(rdy_o),
    .bin_i(bin), .valid_o(vld_o), .ready_i(ready), .onehot_o(onehot), .oob_o(oob)
  );

  bin_to_onehot_stream #(.ONEHOT_WIDTH(12)) u_dut12 (
    .clk_i(clk), .rst_i(rst), .flush_i(flush12), .valid_i(valid12), .ready_o(rdy12_o),
    .bin_i(bin12), .valid_o(vld12_o), .ready_i(ready12), .onehot_o(onehot12), .oob_o(oob12)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  initial begin
    // reset, released on a falling edge; first accept on the next rising edge
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_valid", 32'(vld_o), 32'd0);
    check("rst_onehot", 32'(onehot), 32'd0);
    check("rst_oob", 32'(oob), 32'd0);
    check("rst_ready", 32'(rdy_o), 32'd1);

    // single item
    valid = 1'b1; bin = 4'd5; ready = 1'b1;
    @(negedge clk);
    check("single_valid", 32'(vld_o), 32'd1);
    check("single_onehot", 32'(onehot), 32'h0020);
    check("single_oob", 32'(oob), 32'd0);
    valid = 1'b0;
    @(negedge clk);
    check("single_drain", 32'(vld_o), 32'd0);

    // streaming 0..15
    for (int k = 0; k < 16; k++) begin
      valid = 1'b1; bin = 4'(k);
      #1;
      check("stream_ready", 32'(rdy_o), 32'd1);
      @(negedge clk);
      check("stream_valid", 32'(vld_o), 32'd1);
      check("stream_onehot", 32'(onehot), 32'(16'h1 << k));
    end
    valid = 1'b0;
    @(negedge clk);
    check("stream_drain", 32'(vld_o), 32'd0);

    // out of range on the 12-wide instance
    ready12 = 1'b1; valid12 = 1'b1; bin12 = 4'd13;
    @(negedge clk);
    check("oob_valid", 32'(vld12_o), 32'd1);
    check("oob_onehot", 32'(onehot12), 32'h000);
    check("oob_flag", 32'(oob12), 32'd1);
    bin12 = 4'd11;
    @(negedge clk);
    check("top_onehot", 32'(onehot12), 32'h800);
    check("top_oob", 32'(oob12), 32'd0);
    valid12 = 1'b0;
    @(negedge clk);
    check("w12_drain", 32'(vld12_o), 32'd0);

    // backpressure: offer 3 then 7 with ready low
    ready = 1'b0; valid = 1'b1; bin = 4'd3;
    #1;
    check("bp_ready_first", 32'(rdy_o), 32'd1);
    @(negedge clk);
    check("bp_valid", 32'(vld_o), 32'd1);
    check("bp_onehot3", 32'(onehot), 32'h0008);
    bin = 4'd7;
    #1;
    check("bp_ready_second", 32'(rdy_o), 32'(SKID));
    @(negedge clk);
`ifdef BIN_TO_ONEHOT_SKID_EN
    valid = 1'b0;
`endif
    #1;
    check("bp_full", 32'(rdy_o), 32'd0);
    check("bp_stable1", 32'(onehot), 32'h0008);
    @(negedge clk);
    check("bp_stable2", 32'(onehot), 32'h0008);
    check("bp_stable_valid", 32'(vld_o), 32'd1);
    ready = 1'b1;
    #1;
    check("bp_ready_release", 32'(rdy_o), 32'(!SKID));
    @(negedge clk);
    valid = 1'b0;
    check("bp_second_valid", 32'(vld_o), 32'd1);
    check("bp_onehot7", 32'(onehot), 32'h0080);
    @(negedge clk);
    check("bp_drain", 32'(vld_o), 32'd0);

    // flush with the buffer full
    ready = 1'b0; valid = 1'b1;
    for (int n = 0; n < NPRE; n++) begin
      bin = 4'(2 + 2 * n);
      @(negedge clk);
    end
    check("fl_held", 32'(vld_o), 32'd1);
    flush = 1'b1; bin = 4'd9;
    #1;
    check("fl_ready", 32'(rdy_o), 32'd0);
    @(negedge clk);
    flush = 1'b0; valid = 1'b0;
    #1;
    check("fl_valid", 32'(vld_o), 32'd0);
    check("fl_ready_after", 32'(rdy_o), 32'd1);
    valid = 1'b1; bin = 4'd1; ready = 1'b1;
    @(negedge clk);
    valid = 1'b0;
    check("fl_next_valid", 32'(vld_o), 32'd1);
    check("fl_next_onehot", 32'(onehot), 32'h0002);
    @(negedge clk);
    check("fl_no_ghost", 32'(vld_o), 32'd0);

    // flush with empty buffer is a no-op
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("fl_empty_valid", 32'(vld_o), 32'd0);
    check("fl_empty_ready", 32'(rdy_o), 32'd1);

    // asynchronous reset mid-cycle with one entry held in each instance
    ready = 1'b0; valid = 1'b1; bin = 4'd6;
    ready12 = 1'b0; valid12 = 1'b1; bin12 = 4'd14;
    @(negedge clk);
    valid = 1'b0; valid12 = 1'b0;
    check("ar_held", 32'(vld_o), 32'd1);
    check("ar_held_oob12", 32'(oob12), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("ar_valid", 32'(vld_o), 32'd0);
    check("ar_onehot", 32'(onehot), 32'd0);
    check("ar_oob", 32'(oob), 32'd0);
    check("ar_ready", 32'(rdy_o), 32'd1);
    check("ar_valid12", 32'(vld12_o), 32'd0);
    check("ar_oob12", 32'(oob12), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("ar_stays_empty", 32'(vld_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
